// File: rtl/level_sequencer_pkg.sv
// Shared types and helpers for the level sequencer: FSM state encoding and
// the per-level tick period with saturation at the floor.
package level_seq_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    RUN  = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } state_e;

  // Evaluated at 64 bits, wide enough for any CNT_W+LVL_W in use, so the
  // reduction can never wrap before the floor is applied.
  function automatic logic [63:0] period(input logic [63:0] lvl,
                                         input logic [63:0] base,
                                         input logic [63:0] step,
                                         input logic [63:0] min_p);
    logic [63:0] red;
    red = (lvl == 64'd0) ? 64'd0 : (lvl - 64'd1) * step;
    if (red >= base || (base - red) < min_p) return min_p;
    return base - red;
  endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Control/status bundle between the input debouncer, the level sequencer and
// the row datapath. Carries the pause input when LEVEL_SEQ_PAUSE_EN is defined.
interface level_sequencer_if #(parameter int LVL_W = 4);
  logic             go;
  logic             place;
  logic             place_ok;
`ifdef LEVEL_SEQ_PAUSE_EN
  logic             pause;
`endif
  logic [LVL_W-1:0] level;
  logic             active;
  logic             tick;
  logic             win;
  logic             game_over;

`ifdef LEVEL_SEQ_PAUSE_EN
  modport master (output go, place, place_ok, pause,
                  input  level, active, tick, win, game_over);
  modport slave  (input  go, place, place_ok, pause,
                  output level, active, tick, win, game_over);
`else
  modport master (output go, place, place_ok,
                  input  level, active, tick, win, game_over);
  modport slave  (input  go, place, place_ok,
                  output level, active, tick, win, game_over);
`endif
endinterface

// File: rtl/level_sequencer_tick_divider.sv
// Loadable down-counter for the move strobe; reloads itself from load_val on
// terminal count while enabled, and freezes while hold is high.
module tick_divider #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             hold,
  output logic             tc
);
  logic [CNT_W-1:0] count;

  assign tc = en & ~hold & (count == '0);

  always_ff @(posedge clk) begin
    if (!resetn)          count <= '0;
    else if (load)        count <= load_val;
    else if (en && !hold) count <= (count == '0) ? load_val : count - CNT_W'(1);
  end
endmodule

// File: rtl/level_sequencer.sv
// Level/speed controller for the block stacker. Optional pause input is
// compiled in with LEVEL_SEQ_PAUSE_EN.
module level_sequencer
  import level_seq_pkg::*;
#(
  parameter int NUM_LEVELS  = 15,
  parameter int LVL_W       = 4,
  parameter int CNT_W       = 26,
  parameter int BASE_PERIOD = 50000000,
  parameter int PERIOD_STEP = 3000000,
  parameter int MIN_PERIOD  = 2000000
) (
  input  logic              clk,
  input  logic              resetn,
  level_sequencer_if.slave  bus
);
  state_e           state;
  logic [LVL_W-1:0] level_q;
  logic             tick_q, win_q, over_q;
  logic             paused, place_eff, tc;
  logic [63:0]      per_w;
  logic [CNT_W-1:0] load_val;

`ifdef LEVEL_SEQ_PAUSE_EN
  assign paused = bus.pause & (state == RUN);
`else
  assign paused = 1'b0;
`endif

  // A place pulse only counts in RUN and never while paused.
  assign place_eff = bus.place & ~paused & (state == RUN);

  always_comb begin
    per_w    = period(64'(level_q), 64'(BASE_PERIOD), 64'(PERIOD_STEP), 64'(MIN_PERIOD));
    load_val = per_w[CNT_W-1:0] - CNT_W'(1);
  end

  tick_divider #(.CNT_W(CNT_W)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .load     ((state == WAIT) & bus.go),
    .load_val (load_val),
    .en       ((state == RUN) & ~place_eff),
    .hold     (paused),
    .tc       (tc)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= WAIT;
      level_q <= LVL_W'(1);
      tick_q  <= 1'b0;
      win_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      win_q  <= 1'b0;
      over_q <= 1'b0;
      case (state)
        WAIT: if (bus.go) state <= RUN;
        RUN: begin
          if (place_eff) begin
            if (!bus.place_ok) begin
              state  <= LOST;
              over_q <= 1'b1;
            end else if (level_q == LVL_W'(NUM_LEVELS)) begin
              state <= WON;
              win_q <= 1'b1;
            end else begin
              level_q <= level_q + LVL_W'(1);
              state   <= WAIT;
            end
          end else begin
            tick_q <= tc;
          end
        end
        WON, LOST: begin
          state   <= WAIT;
          level_q <= LVL_W'(1);
        end
        default: begin
          state   <= WAIT;
          level_q <= LVL_W'(1);
        end
      endcase
    end
  end

  assign bus.level     = level_q;
  assign bus.active    = (state == RUN);
  assign bus.tick      = tick_q;
  assign bus.win       = win_q;
  assign bus.game_over = over_q;
endmodule
